// File: rtl/cr16_cond_unit.sv
// CR16 condition-code unit: holds the processor-status register and evaluates
// Bcond/Jcond/Scond condition codes against it with a single registered result.
module cr16_cond_unit #(
    parameter int unsigned P_WIDTH  = 16,
    parameter bit          P_BYPASS = 1'b1
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_STATUS_WE,
    input  logic [4:0]         I_STATUS,
    input  logic               I_PSR_WE,
    input  logic [4:0]         I_PSR_DATA,
    input  logic               I_EVAL_VALID,
    input  logic [3:0]         I_COND,
    input  logic               I_IS_SCOND,
    output logic [4:0]         O_PSR,
    output logic               O_VALID,
    output logic               O_TAKEN,
    output logic [P_WIDTH-1:0] O_SCOND
);

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

    logic [4:0]         psr_q;
    logic [4:0]         psr_d;
    logic               valid_q;
    logic               taken_q;
    logic [P_WIDTH-1:0] scond_q;

    logic [4:0] src_c;
    logic       base_c;
    logic       result_c;

    // Next PSR: software load wins over the ALU status strobe.
    always_comb begin
        psr_d = psr_q;
        if (I_PSR_WE) begin
            psr_d = I_PSR_DATA;
        end else if (I_STATUS_WE) begin
            psr_d = I_STATUS;
        end
    end

    assign src_c = P_BYPASS ? psr_d : psr_q;

    // Codes come in complementary pairs; the odd member inverts the even one.
    always_comb begin
        base_c = 1'b0;
        case (I_COND[3:1])
            3'd0: base_c = src_c[FLAG_Z];
            3'd1: base_c = src_c[FLAG_C];
            3'd2: base_c = src_c[FLAG_L];
            3'd3: base_c = src_c[FLAG_N];
            3'd4: base_c = src_c[FLAG_F];
            3'd5: base_c = ~(src_c[FLAG_L] | src_c[FLAG_Z]);
            3'd6: base_c = ~(src_c[FLAG_N] | src_c[FLAG_Z]);
            3'd7: base_c = 1'b1;
            default: base_c = 1'b0;
        endcase
        result_c = base_c ^ I_COND[0];
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            psr_q   <= 5'd0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            scond_q <= '0;
        end else begin
            psr_q   <= psr_d;
            valid_q <= I_EVAL_VALID;
            if (I_EVAL_VALID) begin
                taken_q <= result_c;
                if (I_IS_SCOND) begin
                    scond_q <= {{(P_WIDTH-1){1'b0}}, result_c};
                end
            end
        end
    end

    assign O_PSR   = psr_q;
    assign O_VALID = valid_q;
    assign O_TAKEN = taken_q;
    assign O_SCOND = scond_q;

endmodule

// File: tb/tb_cr16_cond_unit.sv
// Scoreboard bench for cr16_cond_unit: one bypassing and one non-bypassing
// instance share stimulus; a monitor checks each result pulse against a queue.
module tb_cr16_cond_unit;

    logic       clk;
    logic       rst;
    logic       status_we;
    logic [4:0] status;
    logic       psr_we;
    logic [4:0] psr_data;
    logic       eval_valid;
    logic [3:0] cond;
    logic       is_scond;

    logic [4:0]  psr_b,   psr_n;
    logic        valid_b, valid_n;
    logic        taken_b, taken_n;
    logic [15:0] scond_b, scond_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        tb;
        logic        tn;
        logic [15:0] sb;
        logic [15:0] sn;
    } exp_t;

    exp_t        q[$];
    logic [4:0]  m_psr;
    logic [15:0] m_scond_b;
    logic [15:0] m_scond_n;

    cr16_cond_unit #(.P_WIDTH(16), .P_BYPASS(1'b1)) dut (
        .I_CLK(clk), .I_RESET(rst),
        .I_STATUS_WE(status_we), .I_STATUS(status),
        .I_PSR_WE(psr_we), .I_PSR_DATA(psr_data),
        .I_EVAL_VALID(eval_valid), .I_COND(cond), .I_IS_SCOND(is_scond),
        .O_PSR(psr_b), .O_VALID(valid_b), .O_TAKEN(taken_b), .O_SCOND(scond_b)
    );

    cr16_cond_unit #(.P_WIDTH(16), .P_BYPASS(1'b0)) dut_nb (
        .I_CLK(clk), .I_RESET(rst),
        .I_STATUS_WE(status_we), .I_STATUS(status),
        .I_PSR_WE(psr_we), .I_PSR_DATA(psr_data),
        .I_EVAL_VALID(eval_valid), .I_COND(cond), .I_IS_SCOND(is_scond),
        .O_PSR(psr_n), .O_VALID(valid_n), .O_TAKEN(taken_n), .O_SCOND(scond_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flags: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
    function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] s);
        logic cf, lf, ff, zf, nf;
        cf = s[0]; lf = s[1]; ff = s[2]; zf = s[3]; nf = s[4];
        case (c)
            4'd0:  return zf;
            4'd1:  return !zf;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return lf;
            4'd5:  return !lf;
            4'd6:  return nf;
            4'd7:  return !nf;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !lf && !zf;
            4'd11: return lf || zf;
            4'd12: return !nf && !zf;
            4'd13: return nf || zf;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        status_we  = 1'b0;
        status     = 5'd0;
        psr_we     = 1'b0;
        psr_data   = 5'd0;
        eval_valid = 1'b0;
        cond       = 4'd0;
        is_scond   = 1'b0;
    endtask

    task automatic load(input logic [4:0] d);
        psr_we   = 1'b1;
        psr_data = d;
        @(posedge clk);
        #1;
        idle();
        m_psr = d;
    endtask

    task automatic issue(input logic [3:0] c, input logic sc,
                         input logic pwe, input logic [4:0] pd,
                         input logic swe, input logic [4:0] sd,
                         input logic etb, input logic etn);
        exp_t e;
        eval_valid = 1'b1;
        cond       = c;
        is_scond   = sc;
        psr_we     = pwe;
        psr_data   = pd;
        status_we  = swe;
        status     = sd;
        if (sc) begin
            m_scond_b = {15'd0, etb};
            m_scond_n = {15'd0, etn};
        end
        e = '{tb: etb, tn: etn, sb: m_scond_b, sn: m_scond_n};
        q.push_back(e);
        if (pwe)      m_psr = pd;
        else if (swe) m_psr = sd;
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid_b === 1'b1 || valid_n === 1'b1) begin
            exp_t e;
            chk("valid_byp", 32'(valid_b), 32'd1);
            chk("valid_nb", 32'(valid_n), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("taken_byp", 32'(taken_b), 32'(e.tb));
                chk("taken_nb", 32'(taken_n), 32'(e.tn));
                chk("scond_byp", 32'(scond_b), 32'(e.sb));
                chk("scond_nb", 32'(scond_n), 32'(e.sn));
            end
        end
    end

    initial begin
        idle();
        m_psr = 5'd0; m_scond_b = 16'd0; m_scond_n = 16'd0;
        rst = 1'b1; eval_valid = 1'b1; cond = 4'd14;

        // Reset with a pending request: nothing comes out.
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", 32'(valid_b), 32'd0);
            chk("rst_valid_nb", 32'(valid_n), 32'd0);
            chk("rst_psr", 32'(psr_b), 32'd0);
            chk("rst_scond", 32'(scond_b), 32'd0);
        end
        rst = 1'b0;
        idle();
        issue(4'd14, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);

        // Full table sweep over every PSR value.
        for (int p = 0; p < 32; p++) begin
            load(5'(p));
            chk("sweep_psr", 32'(psr_b), 32'(p));
            for (int c = 0; c < 16; c++) begin
                issue(4'(c), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,
                      cond_ref(4'(c), 5'(p)), cond_ref(4'(c), 5'(p)));
            end
        end

        // Spot checks with hand values.
        load(5'b01000);
        issue(4'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd13, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        issue(4'd12, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        load(5'b00010);
        issue(4'd4,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Scond results, then a branch must leave O_SCOND alone.
        load(5'b10000);
        issue(4'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        issue(4'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("scond_hold", 32'(scond_b), 32'h0000);

        // Bypass vs. no bypass on a same-cycle status write.
        load(5'b00000);
        issue(4'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'b01000, 1'b1, 1'b0);
        @(negedge clk);
        chk("byp_psr", 32'(psr_b), 32'b01000);
        chk("byp_psr_nb", 32'(psr_n), 32'b01000);

        // PSR load beats status write.
        issue(4'd2, 1'b0, 1'b1, 5'b00001, 1'b1, 5'b11110, 1'b1, 1'b0);
        @(negedge clk);
        chk("prio_psr", 32'(psr_b), 32'b00001);
        chk("prio_psr_nb", 32'(psr_n), 32'b00001);

        // Back-to-back requests, then the taken flag holds.
        load(5'b01000);
        issue(4'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd1,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        issue(4'd14, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        issue(4'd15, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stream_valid_off", 32'(valid_b), 32'd0);
        chk("stream_taken_hold", 32'(taken_b), 32'd0);
        chk("stream_drained", 32'(q.size()), 32'd0);

        // Reset while a result is showing, with a request in the reset cycle.
        issue(4'd14, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        rst = 1'b1; eval_valid = 1'b1; cond = 4'd14; is_scond = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        m_psr = 5'd0; m_scond_b = 16'd0; m_scond_n = 16'd0;
        chk("rst2_valid", 32'(valid_b), 32'd0);
        chk("rst2_psr", 32'(psr_b), 32'd0);
        chk("rst2_taken", 32'(taken_b), 32'd0);
        chk("rst2_scond", 32'(scond_b), 32'd0);
        @(posedge clk);
        #1;
        chk("rst2_no_late_valid", 32'(valid_b), 32'd0);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr16_cond_unit.md
Name: cr16_cond_unit

Overview:
- Condition-code end of the ALU status path.
- Latches the 5-bit ALU status word (C, L, F, Z, N) into a processor-status register (PSR).
- Evaluates 4-bit CR16 condition codes against the PSR for Bcond/Jcond (taken flag) and Scond (0/1 word written to a register).
- Sits between the ALU status output and the branch/writeback logic; one registered result per evaluation request.

Parameters:
P_WIDTH, 16, width of the Scond result word
P_BYPASS, 1, 1 = an evaluation in the same cycle as a status write uses the incoming status; 0 = uses the PSR value before the write

Ports:
I_CLK  input  1  clock, rising edge
I_RESET  input  1  synchronous active-high reset
I_STATUS_WE  input  1  ALU status write strobe
I_STATUS  input  5  ALU status: bit0 C(carry), bit1 L(low), bit2 F(flag), bit3 Z(zero), bit4 N(negative)
I_PSR_WE  input  1  software PSR load (restore after interrupt/LPR)
I_PSR_DATA  input  5  PSR load value, same bit layout
I_EVAL_VALID  input  1  condition evaluation request
I_COND  input  4  condition code
I_IS_SCOND  input  1  1 = Scond request (drive O_SCOND), 0 = branch request
O_PSR  output  5  current PSR contents
O_VALID  output  1  one-cycle pulse, result valid
O_TAKEN  output  1  condition true
O_SCOND  output  P_WIDTH  zero-extended condition result (Scond only)

Behaviour:
- Reset (I_RESET=1 at a rising edge): O_PSR=0, O_VALID=0, O_TAKEN=0, O_SCOND=0. Any in-flight request is discarded. A request presented in the reset cycle produces no O_VALID.
- PSR update, per edge:
  - I_PSR_WE has priority over I_STATUS_WE when both are high; PSR <= I_PSR_DATA.
  - Otherwise, if I_STATUS_WE=1, PSR <= I_STATUS.
  - Otherwise PSR holds.
- Evaluation source flags S:
  - With P_BYPASS=1, S = the value PSR will take at this edge (I_PSR_DATA if I_PSR_WE, else I_STATUS if I_STATUS_WE, else PSR).
  - With P_BYPASS=0, S = current PSR.
- Condition table (I_COND -> true when):
  - 0 EQ: Z=1
  - 1 NE: Z=0
  - 2 CS: C=1
  - 3 CC: C=0
  - 4 HI: L=1
  - 5 LS: L=0
  - 6 GT: N=1
  - 7 LE: N=0
  - 8 FS: F=1
  - 9 FC: F=0
  - 10 LO: L=0 and Z=0
  - 11 HS: L=1 or Z=1
  - 12 LT: N=0 and Z=0
  - 13 GE: N=1 or Z=1
  - 14 UC: always
  - 15 NV: never
- Latency: exactly 1 cycle. I_EVAL_VALID sampled high at edge k gives O_VALID=1 during cycle k+1. O_VALID deasserts the cycle after unless a new request was sampled; back-to-back requests every cycle are legal and give back-to-back pulses.
- O_TAKEN:
  - Updated only when a request is sampled, otherwise it holds its last value.
  - Set to the table result for both branch and Scond requests.
- O_SCOND:
  - On an Scond request: {P_WIDTH-1 zeros, result}.
  - On a branch request or no request: O_SCOND holds.
- No backpressure: the consumer must accept O_VALID when it pulses.
- The PSR is never modified by an evaluation. Unused PSR bits beyond [4:0] do not exist.
- Reset asserted during the cycle O_VALID is high clears O_VALID at that edge.

Test Plan:
- Reset: hold I_RESET 2 cycles with I_EVAL_VALID=1, I_COND=14 -> O_VALID=0, O_PSR=0, O_SCOND=0 throughout. First request after release -> O_VALID one cycle later, O_TAKEN=1.
- Full table sweep: for each of the 32 PSR values (loaded via I_PSR_WE), evaluate all 16 codes as branch requests -> O_TAKEN matches the table. Spot checks: PSR=5'b01000 (Z) gives EQ=1, HS=1, GE=1, LO=0, LT=0; PSR=5'b00010 (L) gives HI=1, HS=1, LO=0.
- Scond: PSR=5'b10000, I_IS_SCOND=1, I_COND=6 -> O_SCOND=16'h0001. Next request I_COND=7 -> O_SCOND=16'h0000. A following branch request leaves O_SCOND=16'h0000.
- Bypass: PSR=0, same cycle I_STATUS_WE=1, I_STATUS=5'b01000, eval EQ -> P_BYPASS=1 gives O_TAKEN=1; P_BYPASS=0 gives O_TAKEN=0. Both configurations then show O_PSR=5'b01000.
- Write priority: I_PSR_WE=1 with I_PSR_DATA=5'b00001 and I_STATUS_WE=1 with I_STATUS=5'b11110 in the same cycle -> O_PSR=5'b00001; a bypassed CS evaluation in that cycle gives O_TAKEN=1.
- Streaming/hold: requests on 4 consecutive cycles with codes 0, 1, 14, 15 on PSR=Z -> O_VALID high 4 cycles, O_TAKEN 1,0,1,0. After the last pulse, O_VALID=0 and O_TAKEN holds 0.
